// File: rtl/program_boot_loader_if.sv
// Loader bus: program word stream in, memory write port and CPU boot control out.
interface program_boot_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              LoadValid;
  logic [DATA_W-1:0] LoadData;
  logic              LoadLast;
  logic              LoadReady;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              CpuRst;
  logic              Booting;
  logic [ADDR_W:0]   LoadCount;
  logic              Error;

  // Program source / observer side
  modport master (
    output LoadValid, LoadData, LoadLast,
    input  LoadReady, MemWE, MemAddr, MemData, CpuRst, Booting, LoadCount, Error
  );

  // Loader side
  modport slave (
    input  LoadValid, LoadData, LoadLast,
    output LoadReady, MemWE, MemAddr, MemData, CpuRst, Booting, LoadCount, Error
  );
endinterface

// File: rtl/program_boot_loader.sv
// Boot loader: holds the CPU in reset, streams a program into memory, lets the
// memory settle, then releases the CPU. Overflowing memory parks in ERR.
module program_boot_loader #(
  parameter int                ADDR_W        = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int                HOLD_CYCLES   = 4,
  parameter int                SETTLE_CYCLES = 3
) (
  input logic                  CLK,
  input logic                  CtrlRst,
  program_boot_loader_if.slave bus
);
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = 16;
  localparam logic [ADDR_W:0]  LAST_IDX    = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {HOLD, LOAD, SETTLE, RUN, ERR} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W:0]   loadCount, loadCountNext;
  logic              memWe, memWeNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [DATA_W-1:0] memData, memDataNext;
  logic              loadReady, loadReadyNext;
  logic              cpuRst, cpuRstNext;
  logic              booting, bootingNext;
  logic              error, errorNext;
  logic              handshake;

  // loadReady is high only in LOAD, so a handshake implies the LOAD state
  assign handshake = bus.LoadValid & loadReady;

  // State and registered outputs; reset drops any write pending this cycle
  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      state     <= HOLD;
      cnt       <= '0;
      loadCount <= '0;
      memWe     <= 1'b0;
      memAddr   <= BASE_ADDR;
      memData   <= '0;
      loadReady <= 1'b0;
      cpuRst    <= 1'b1;
      booting   <= 1'b1;
      error     <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      loadCount <= loadCountNext;
      memWe     <= memWeNext;
      memAddr   <= memAddrNext;
      memData   <= memDataNext;
      loadReady <= loadReadyNext;
      cpuRst    <= cpuRstNext;
      booting   <= bootingNext;
      error     <= errorNext;
    end
  end

  // Next-state sequencing: hold -> load -> settle -> run, or load -> err on overflow
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      HOLD: begin
        if (cnt == HOLD_END) begin
          stateNext = LOAD;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      LOAD: begin
        if (handshake) begin
          // LoadLast wins over overflow: a program exactly filling memory is legal
          if (bus.LoadLast) begin
            stateNext = SETTLE;
          end else if (loadCount == LAST_IDX) begin
            stateNext = ERR;
          end
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_END) begin
          stateNext = RUN;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Next values of the registered outputs; write port follows the handshake one cycle later
  always_comb begin
    memWeNext     = handshake;
    memAddrNext   = memAddr;
    memDataNext   = memData;
    loadCountNext = loadCount;
    if (handshake) begin
      // Address arithmetic wraps naturally at ADDR_W bits
      memAddrNext   = BASE_ADDR + loadCount[ADDR_W-1:0];
      memDataNext   = bus.LoadData;
      loadCountNext = loadCount + (ADDR_W + 1)'(1);
    end
    loadReadyNext = (stateNext == LOAD);
    cpuRstNext    = (stateNext != RUN);
    bootingNext   = (stateNext != RUN);
    errorNext     = (stateNext == ERR);
  end

  assign bus.LoadReady = loadReady;
  assign bus.MemWE     = memWe;
  assign bus.MemAddr   = memAddr;
  assign bus.MemData   = memData;
  assign bus.CpuRst    = cpuRst;
  assign bus.Booting   = booting;
  assign bus.LoadCount = loadCount;
  assign bus.Error     = error;

endmodule

// File: tb/tb_program_boot_loader.sv
// Directed bench for program_boot_loader: default, tiny-memory and wrapping-base instances.
module tb_program_boot_loader;
  logic CLK;
  logic rstA, rstB, rstC;
  int   assertCnt;
  int   failCnt;

  program_boot_loader_if #(.ADDR_W(10)) ifA ();
  program_boot_loader_if #(.ADDR_W(2))  ifB ();
  program_boot_loader_if #(.ADDR_W(10)) ifC ();

  program_boot_loader #(.ADDR_W(10)) dutA (.CLK(CLK), .CtrlRst(rstA), .bus(ifA.slave));
  program_boot_loader #(.ADDR_W(2))  dutB (.CLK(CLK), .CtrlRst(rstB), .bus(ifB.slave));
  program_boot_loader #(.ADDR_W(10), .BASE_ADDR(10'h3FE))
                                     dutC (.CLK(CLK), .CtrlRst(rstC), .bus(ifC.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit past the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One reset cycle on instance A, then wait out the 4-cycle hold
  task automatic bootA();
    rstA = 1'b0;
    ifA.LoadValid = 1'b0;
    tick();
    rstA = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    logic [15:0] wordsT2 [3];
    logic [9:0]  addrsC  [3];
    int w;
    int pulses;
    assertCnt = 0;
    failCnt   = 0;
    wordsT2[0] = 16'h1111; wordsT2[1] = 16'h2222; wordsT2[2] = 16'h3333;
    addrsC[0]  = 10'h3FE;  addrsC[1]  = 10'h3FF;  addrsC[2]  = 10'h000;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    ifA.LoadValid = 1'b0; ifA.LoadData = '0; ifA.LoadLast = 1'b0;
    ifB.LoadValid = 1'b0; ifB.LoadData = '0; ifB.LoadLast = 1'b0;
    ifC.LoadValid = 1'b0; ifC.LoadData = '0; ifC.LoadLast = 1'b0;

    // Reset state
    tick();
    tick();
    checkEq("rst LoadReady", 32'(ifA.LoadReady), 0);
    checkEq("rst MemWE",     32'(ifA.MemWE), 0);
    checkEq("rst MemAddr",   32'(ifA.MemAddr), 0);
    checkEq("rst MemData",   32'(ifA.MemData), 0);
    checkEq("rst CpuRst",    32'(ifA.CpuRst), 1);
    checkEq("rst Booting",   32'(ifA.Booting), 1);
    checkEq("rst LoadCount", 32'(ifA.LoadCount), 0);
    checkEq("rst Error",     32'(ifA.Error), 0);
    checkEq("rstC MemAddr",  32'(ifC.MemAddr), 32'h3FE);

    // Test 1: hold lasts exactly 4 cycles
    rstA = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkEq($sformatf("t1 LoadReady c%0d", i), 32'(ifA.LoadReady), (i == 4) ? 1 : 0);
      checkEq($sformatf("t1 CpuRst c%0d", i), 32'(ifA.CpuRst), 1);
      checkEq($sformatf("t1 MemWE c%0d", i), 32'(ifA.MemWE), 0);
    end

    // Test 2: three back-to-back words, settle, run
    for (int i = 0; i < 3; i++) begin
      ifA.LoadValid = 1'b1;
      ifA.LoadData  = wordsT2[i];
      ifA.LoadLast  = (i == 2);
      tick();
      checkEq($sformatf("t2 MemWE w%0d", i), 32'(ifA.MemWE), 1);
      checkEq($sformatf("t2 MemAddr w%0d", i), 32'(ifA.MemAddr), i);
      checkEq($sformatf("t2 MemData w%0d", i), 32'(ifA.MemData), 32'(wordsT2[i]));
    end
    ifA.LoadValid = 1'b0;
    ifA.LoadLast  = 1'b0;
    checkEq("t2 LoadCount", 32'(ifA.LoadCount), 3);
    checkEq("t2 LoadReady", 32'(ifA.LoadReady), 0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      checkEq($sformatf("t2 CpuRst s%0d", j), 32'(ifA.CpuRst), (j < 3) ? 1 : 0);
      checkEq($sformatf("t2 Booting s%0d", j), 32'(ifA.Booting), (j < 3) ? 1 : 0);
      checkEq($sformatf("t2 MemWE s%0d", j), 32'(ifA.MemWE), 0);
    end
    ifA.LoadValid = 1'b1;
    ifA.LoadData  = 16'hFFFF;
    tick();
    tick();
    checkEq("t2 run MemWE", 32'(ifA.MemWE), 0);
    checkEq("t2 run LoadCount", 32'(ifA.LoadCount), 3);

    // Test 3: valid every other cycle, junk data/last while idle
    bootA();
    checkEq("t3 LoadReady", 32'(ifA.LoadReady), 1);
    w = 0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        ifA.LoadValid = 1'b1;
        ifA.LoadData  = 16'hA000 + 16'(w);
        ifA.LoadLast  = (w == 3);
      end else begin
        ifA.LoadValid = 1'b0;
        ifA.LoadData  = 16'hDEAD;
        ifA.LoadLast  = 1'b1;
      end
      tick();
      if (ifA.MemWE) pulses++;
      if (c % 2 == 0) begin
        checkEq($sformatf("t3 MemWE c%0d", c), 32'(ifA.MemWE), 1);
        checkEq($sformatf("t3 MemAddr c%0d", c), 32'(ifA.MemAddr), w);
        checkEq($sformatf("t3 MemData c%0d", c), 32'(ifA.MemData), 32'h0000A000 + w);
        w++;
      end else begin
        checkEq($sformatf("t3 MemWE c%0d", c), 32'(ifA.MemWE), 0);
      end
    end
    ifA.LoadValid = 1'b0;
    ifA.LoadLast  = 1'b0;
    checkEq("t3 pulses", 32'(pulses), 4);
    checkEq("t3 LoadCount", 32'(ifA.LoadCount), 4);

    // Test 5: reset in the middle of a load drops the pending write
    bootA();
    for (int i = 0; i < 2; i++) begin
      ifA.LoadValid = 1'b1;
      ifA.LoadData  = 16'h5000 + 16'(i);
      ifA.LoadLast  = 1'b0;
      tick();
    end
    checkEq("t5 LoadCount pre", 32'(ifA.LoadCount), 2);
    rstA = 1'b0;
    ifA.LoadData = 16'h5555;
    tick();
    checkEq("t5 MemWE", 32'(ifA.MemWE), 0);
    checkEq("t5 LoadCount", 32'(ifA.LoadCount), 0);
    checkEq("t5 CpuRst", 32'(ifA.CpuRst), 1);
    checkEq("t5 MemAddr", 32'(ifA.MemAddr), 0);
    checkEq("t5 LoadReady", 32'(ifA.LoadReady), 0);
    rstA = 1'b1;
    ifA.LoadValid = 1'b0;
    repeat (4) tick();
    checkEq("t5 reload ready", 32'(ifA.LoadReady), 1);
    ifA.LoadValid = 1'b1;
    ifA.LoadData  = 16'h7777;
    ifA.LoadLast  = 1'b1;
    tick();
    ifA.LoadValid = 1'b0;
    ifA.LoadLast  = 1'b0;
    checkEq("t5 reload MemWE", 32'(ifA.MemWE), 1);
    checkEq("t5 reload MemAddr", 32'(ifA.MemAddr), 0);
    checkEq("t5 reload MemData", 32'(ifA.MemData), 32'h7777);

    // Test 4: 4-word memory overflows without LoadLast
    rstB = 1'b1;
    repeat (4) tick();
    checkEq("t4 LoadReady", 32'(ifB.LoadReady), 1);
    for (int i = 0; i < 4; i++) begin
      ifB.LoadValid = 1'b1;
      ifB.LoadData  = 16'hB000 + 16'(i);
      ifB.LoadLast  = 1'b0;
      tick();
      checkEq($sformatf("t4 MemWE w%0d", i), 32'(ifB.MemWE), 1);
      checkEq($sformatf("t4 MemAddr w%0d", i), 32'(ifB.MemAddr), i);
      checkEq($sformatf("t4 Error w%0d", i), 32'(ifB.Error), (i == 3) ? 1 : 0);
    end
    checkEq("t4 LoadReady err", 32'(ifB.LoadReady), 0);
    checkEq("t4 CpuRst err", 32'(ifB.CpuRst), 1);
    ifB.LoadData = 16'hBBBB;
    tick();
    checkEq("t4 5th MemWE", 32'(ifB.MemWE), 0);
    tick();
    checkEq("t4 LoadCount", 32'(ifB.LoadCount), 4);
    checkEq("t4 Error sticky", 32'(ifB.Error), 1);
    checkEq("t4 Booting", 32'(ifB.Booting), 1);
    ifB.LoadValid = 1'b0;

    // Test 6: base near the top of memory wraps to address 0
    rstC = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      ifC.LoadValid = 1'b1;
      ifC.LoadData  = 16'hC000 + 16'(i);
      ifC.LoadLast  = (i == 2);
      tick();
      checkEq($sformatf("t6 MemWE w%0d", i), 32'(ifC.MemWE), 1);
      checkEq($sformatf("t6 MemAddr w%0d", i), 32'(ifC.MemAddr), 32'(addrsC[i]));
    end
    checkEq("t6 Error", 32'(ifC.Error), 0);
    ifC.LoadValid = 1'b0;
    ifC.LoadLast  = 1'b0;
    repeat (3) tick();
    checkEq("t6 CpuRst run", 32'(ifC.CpuRst), 0);
    ifC.LoadValid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checkEq($sformatf("t6 run MemWE c%0d", j), 32'(ifC.MemWE), 0);
    end
    checkEq("t6 LoadCount", 32'(ifC.LoadCount), 3);
    checkEq("t6 Error run", 32'(ifC.Error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
